// File: rtl/i2s_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_receiver_pkg
//  Description : Shared definitions for the I2S receive path: default sample
//                width, left-channel word-select level, FSM state encoding and
//                a helper that sizes the bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_receiver_pkg;

    localparam int   SAMPLE_WIDTH_DEF = 24;
    localparam logic LRCLK_LEFT       = 1'b0;

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_LEFT   = 3'd1,
        ST_SKIP_L = 3'd2,
        ST_RIGHT  = 3'd3,
        ST_PUSH   = 3'd4,
        ST_SKIP_R = 3'd5
    } rx_state_e;

    // Counter must reach SLOT_WIDTH+1 for the skip timeout.
    function automatic int cnt_width(input int slot_width);
        return $clog2(slot_width + 3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_receiver_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_receiver_fifo
//  Description : Show-ahead register-array FIFO. Head word is presented on
//                rd_data_o whenever not empty (zero while empty). Pointers
//                carry one extra wrap bit so full and empty are distinct.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_receiver_fifo #(
    parameter int WIDTH      = 48,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_q;

    logic [DEPTH_LOG2:0] w_level;
    logic                w_empty;
    logic                w_full;
    logic                w_do_rd;
    logic                w_do_wr;

    assign w_level = wr_ptr_q - rd_ptr_q;
    assign w_empty = (w_level == '0);
    assign w_full  = w_level[DEPTH_LOG2];
    assign w_do_rd = rd_en_i & ~w_empty;
    // A pop in the same cycle frees the slot being written when full.
    assign w_do_wr = wr_en_i & (~w_full | w_do_rd);

    // Storage array; contents need no reset because the output is masked while empty.
    always_ff @(posedge clk_i) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
        end
    end

    // Read and write pointers with wrap bit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign rd_data_o = w_empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign empty_o   = w_empty;
    assign level_o   = w_level;

endmodule
`default_nettype wire

// File: rtl/i2s_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_receiver
//  Description : I2S stereo capture into the clk domain. Synchronises
//                bclk/lrclk/sdata, detects bclk rises, deserialises 24-bit
//                left/right words (one-bit delay after word select changes)
//                and queues completed frames in a show-ahead FIFO.
//                Optional macro I2S_RX_LEVEL_EN adds the FIFO occupancy port.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_receiver
    import i2s_receiver_pkg::*;
#(
    parameter int SAMPLE_WIDTH    = SAMPLE_WIDTH_DEF,
    parameter int SLOT_WIDTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bclk,
    input  logic                      lrclk,
    input  logic                      sdata,
    output logic [SAMPLE_WIDTH-1:0]   frame_out_l,
    output logic [SAMPLE_WIDTH-1:0]   frame_out_r,
    output logic                      empty,
    input  logic                      read_frame,
    output logic                      overflow,
    input  logic                      clear_overflow
`ifdef I2S_RX_LEVEL_EN
    ,
    output logic [FIFO_DEPTH_LOG2:0]  level
`endif
);

    localparam int                CNT_W       = cnt_width(SLOT_WIDTH);
    localparam logic [CNT_W-1:0]  c_LAST_BIT  = CNT_W'(SAMPLE_WIDTH - 1);
    localparam logic [CNT_W-1:0]  c_SKIP_MAX  = CNT_W'(SLOT_WIDTH + 1);

    logic [1:0]              bclk_sync_q;
    logic [1:0]              lrclk_sync_q;
    logic [1:0]              sdata_sync_q;
    logic                    bclk_prev_q;
    logic                    lr_prev_q;

    rx_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SAMPLE_WIDTH-1:0] sh_l_q, sh_l_d;
    logic [SAMPLE_WIDTH-1:0] sh_r_q, sh_r_d;
    logic                    overflow_q;

    logic                    w_rise;
    logic                    w_lr;
    logic                    w_sd;
    logic                    w_bound;
    logic                    w_push;
    logic                    w_full;
    logic                    w_fifo_empty;
    logic [2*SAMPLE_WIDTH-1:0] w_head;
    logic [FIFO_DEPTH_LOG2:0]  w_level;

    // Two-flop synchronisers for the three serial-side inputs plus bclk history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            sdata_sync_q <= '0;
            bclk_prev_q  <= 1'b0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[0], bclk};
            lrclk_sync_q <= {lrclk_sync_q[0], lrclk};
            sdata_sync_q <= {sdata_sync_q[0], sdata};
            bclk_prev_q  <= bclk_sync_q[1];
        end
    end

    assign w_rise  = bclk_sync_q[1] & ~bclk_prev_q;
    assign w_lr    = lrclk_sync_q[1];
    assign w_sd    = sdata_sync_q[1];
    assign w_bound = w_rise & (w_lr != lr_prev_q);

    // Word-select value seen at the previous bclk rise, for boundary detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lr_prev_q <= 1'b0;
        end else if (w_rise) begin
            lr_prev_q <= w_lr;
        end
    end

    // Capture FSM and shift-register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            sh_l_q  <= '0;
            sh_r_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_l_q  <= sh_l_d;
            sh_r_q  <= sh_r_d;
        end
    end

    // Next-state: a boundary rise carries the previous word's LSB, so the
    // MSB of the new word arrives on the following rise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_l_d  = sh_l_q;
        sh_r_d  = sh_r_q;
        w_push  = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (w_bound && (w_lr == LRCLK_LEFT)) begin
                    state_d = ST_LEFT;
                    cnt_d   = '0;
                end
            end
            ST_LEFT, ST_RIGHT: begin
                if (w_bound) begin
                    // Word ended early: drop the partial frame.
                    cnt_d   = '0;
                    state_d = (w_lr == LRCLK_LEFT) ? ST_LEFT : ST_SYNC;
                end else if (w_rise) begin
                    if (state_q == ST_LEFT) begin
                        sh_l_d = {sh_l_q[SAMPLE_WIDTH-2:0], w_sd};
                    end else begin
                        sh_r_d = {sh_r_q[SAMPLE_WIDTH-2:0], w_sd};
                    end
                    if (cnt_q == c_LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = (state_q == ST_LEFT) ? ST_SKIP_L : ST_PUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PUSH: begin
                w_push  = 1'b1;
                cnt_d   = '0;
                state_d = ST_SKIP_R;
            end
            ST_SKIP_L, ST_SKIP_R: begin
                if (w_bound) begin
                    cnt_d = '0;
                    if (w_lr == LRCLK_LEFT) begin
                        state_d = ST_LEFT;
                    end else begin
                        state_d = (state_q == ST_SKIP_L) ? ST_RIGHT : ST_SYNC;
                    end
                end else if (w_rise) begin
                    if (cnt_q == c_SKIP_MAX) begin
                        cnt_d   = '0;
                        state_d = ST_SYNC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_SYNC;
                cnt_d   = '0;
            end
        endcase
    end

    i2s_receiver_fifo #(
        .WIDTH      (2 * SAMPLE_WIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_en_i   (w_push),
        .wr_data_i ({sh_l_q, sh_r_q}),
        .rd_en_i   (read_frame),
        .rd_data_o (w_head),
        .empty_o   (w_fifo_empty),
        .level_o   (w_level)
    );

    assign w_full = w_level[FIFO_DEPTH_LOG2];

    // Sticky drop flag; a clear request beats a simultaneous drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (clear_overflow) begin
            overflow_q <= 1'b0;
        end else if (w_push && w_full && !read_frame) begin
            overflow_q <= 1'b1;
        end
    end

    assign frame_out_l = w_head[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
    assign frame_out_r = w_head[SAMPLE_WIDTH-1:0];
    assign empty       = w_fifo_empty;
    assign overflow    = overflow_q;
`ifdef I2S_RX_LEVEL_EN
    assign level       = w_level;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_receiver
//  Description : Self-checking bench for i2s_receiver. An I2S bus model
//                drives bclk = clk/8; a frame-level reference model decides
//                from slot lengths which frames are captured and keeps the
//                expected FIFO contents and overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_receiver;

    localparam int SW    = 24;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          read_frame;
    logic          clear_overflow;
    logic [SW-1:0] frame_out_l;
    logic [SW-1:0] frame_out_r;
    logic          empty;
    logic          overflow;
`ifdef I2S_RX_LEVEL_EN
    logic [3:0]    level;
`endif

    i2s_receiver dut (
        .clk            (clk),
        .reset          (reset),
        .bclk           (bclk),
        .lrclk          (lrclk),
        .sdata          (sdata),
        .frame_out_l    (frame_out_l),
        .frame_out_r    (frame_out_r),
        .empty          (empty),
        .read_frame     (read_frame),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef I2S_RX_LEVEL_EN
        ,
        .level          (level)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [47:0] exp_q[$];
    logic        exp_ovf = 1'b0;
    logic        prev_bit = 1'b0;

    task automatic check_eq(input string tag, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One bit period, entered and left at a clk falling edge. The serial
    // data lags word select by one period (I2S one-bit delay).
    task automatic bit_period(input logic lr, input logic b, input bit pulse);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = prev_bit;
        prev_bit = b;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (3) @(negedge clk);
        if (pulse) begin
            if (exp_q.size() > 0) begin
                check_eq("push_rd_head", {frame_out_l, frame_out_r}, exp_q[0]);
                void'(exp_q.pop_front());
            end
            read_frame = 1'b1;
        end
        @(negedge clk);
        read_frame = 1'b0;
    endtask

    task automatic send_slot(input logic lr, input logic [SW-1:0] smp, input int n,
                             input logic [39:0] pad, input int pulse_idx);
        logic [63:0] bits;
        bits = {smp, pad};
        for (int i = 0; i < n; i++) begin
            bit_period(lr, bits[63-i], i == pulse_idx);
        end
    endtask

    // Frame-level model: left word needs 24 bits before the next boundary and
    // no skip timeout (SLOT_WIDTH+2 idle rises) before the right boundary;
    // right word needs 24 bits. Its own skip timeout does not lose the frame.
    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r,
                              input int nl, input int nr, input logic [39:0] pad,
                              input bit rd_in_push);
        send_slot(1'b0, l, nl, pad, -1);
        send_slot(1'b1, r, nr, pad, rd_in_push ? 24 : -1);
        if (nl >= 25 && nl <= 58 && nr >= 25) begin
            if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back({l, r});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_empty"}, 48'(empty), 48'(exp_q.size() == 0));
        check_eq({tag, "_ovf"}, 48'(overflow), 48'(exp_ovf));
        if (exp_q.size() > 0) check_eq({tag, "_head"}, {frame_out_l, frame_out_r}, exp_q[0]);
`ifdef I2S_RX_LEVEL_EN
        check_eq({tag, "_level"}, 48'(level), 48'(exp_q.size()));
`endif
    endtask

    task automatic do_read(input string tag);
        if (exp_q.size() > 0) begin
            check_eq({tag, "_rd"}, {frame_out_l, frame_out_r}, exp_q[0]);
            void'(exp_q.pop_front());
        end
        read_frame = 1'b1;
        @(negedge clk);
        read_frame = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [39:0] rpad();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[39:0];
    endfunction

    initial begin
        int nl, nr, nrd;
        reset = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
        read_frame = 1'b0; clear_overflow = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_frame", {frame_out_l, frame_out_r}, 48'h0);
        check_state("rst");

        // Prime word select high so the first left word has a boundary.
        send_slot(1'b1, 24'(SW'($urandom())), 32, rpad(), -1);

        // Basic capture and pop.
        send_frame(24'hA5A5A5, 24'h5A5A5A, 32, 32, rpad(), 1'b0);
        check_state("t1");
        do_read("t1");
        check_state("t1_pop");

        // Trailing slot bits all ones.
        send_frame(24'h800001, 24'h7FFFFF, 32, 32, 40'hFF_FFFF_FFFF, 1'b0);
        check_state("t2");
        do_read("t2");

        // Overflow on the ninth frame, ordered readback, clear.
        for (int i = 1; i <= 9; i++) send_frame(SW'(i), SW'(i), 32, 32, rpad(), 1'b0);
        check_state("t3");
        for (int i = 0; i < 8; i++) do_read("t3");
        check_state("t3_drained");
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        check_state("t3_clr");

        // Full FIFO with a read in the push cycle.
        for (int i = 1; i <= 8; i++) send_frame(SW'(i), SW'(i), 32, 32, rpad(), 1'b0);
        check_state("t4_full");
        send_frame(24'd9, 24'd9, 32, 32, rpad(), 1'b1);
        check_state("t4");
        for (int i = 0; i < 8; i++) do_read("t4");
        check_state("t4_drained");

        // Early left boundary after 10 bits discards that frame.
        send_frame(24'h0BAD00, 24'h0BAD11, 11, 32, rpad(), 1'b0);
        send_frame(24'h123456, 24'h654321, 32, 32, rpad(), 1'b0);
        check_state("t5");
        do_read("t5");

        // Reset in the middle of a right word.
        send_frame(24'h111111, 24'h222222, 32, 32, rpad(), 1'b0);
        send_slot(1'b0, 24'h333333, 32, rpad(), -1);
        send_slot(1'b1, 24'h444444, 12, rpad(), -1);
        reset = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_state("t6_rst");
        send_slot(1'b1, 24'h555555, 20, rpad(), -1);
        send_frame(24'hC0FFEE, 24'hBEEF01, 32, 32, rpad(), 1'b0);
        check_state("t6");
        do_read("t6");

        // Randomised frames, slot lengths, reads and clears.
        for (int f = 0; f < 36; f++) begin
            case ($urandom_range(0, 9))
                0:       nl = $urandom_range(16, 24);
                1:       nl = 25;
                2:       nl = 64;
                3:       nl = $urandom_range(26, 40);
                default: nl = 32;
            endcase
            case ($urandom_range(0, 7))
                0:       nr = 20;
                1:       nr = 64;
                default: nr = 32;
            endcase
            send_frame(SW'($urandom()), SW'($urandom()), nl, nr, rpad(), 1'b0);
            check_state("rnd");
            nrd = $urandom_range(0, 2);
            for (int j = 0; j < nrd; j++) do_read("rnd");
            if ($urandom_range(0, 7) == 0) begin
                clear_overflow = 1'b1;
                @(negedge clk);
                clear_overflow = 1'b0;
                exp_ovf = 1'b0;
                @(negedge clk);
            end
            check_state("rnd_post");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
